// File: rtl/calc_key_input.sv
// rtl/calc_key_input.sv - key front-end: synchronise, debounce and classify calculator key presses
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   key_btn   raw bouncing "enter key" push-button
//   key_code  raw 4-bit key-code switches, held by the user while the button is down
//   rec_num   one-cycle pulse: accepted key was a digit (0-9)
//   rec_op    one-cycle pulse: accepted key was an operator or equals (10-14)
//   clr_req   one-cycle pulse: accepted key was clear (15)
//   digit     last accepted digit, valid with rec_num and held afterwards
//   op_code   last accepted operator (0 add, 1 sub, 2 mul, 3 div, 4 equals)
//   busy      high from press detection until the release has been debounced
module calc_key_input #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_btn,
    input  logic [3:0] key_code,
    output logic       rec_num,
    output logic       rec_op,
    output logic       clr_req,
    output logic [3:0] digit,
    output logic [2:0] op_code,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        FIRE,
        WAIT_REL,
        DB_REL
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Two-flop synchronisers for the asynchronous button and code switches.
    logic       btn_m;
    logic       btn_s;
    logic [3:0] code_m;
    logic [3:0] code_s;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       code_cap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_m    <= 1'b0;
            btn_s    <= 1'b0;
            code_m   <= 4'd0;
            code_s   <= 4'd0;
            state    <= IDLE;
            cnt      <= '0;
            code_cap <= 4'd0;
            rec_num  <= 1'b0;
            rec_op   <= 1'b0;
            clr_req  <= 1'b0;
            digit    <= 4'd0;
            op_code  <= 3'd0;
            busy     <= 1'b0;
        end else begin
            btn_m  <= key_btn;
            btn_s  <= btn_m;
            code_m <= key_code;
            code_s <= code_m;

            // Pulses default low; only the FIRE state raises one of them.
            rec_num <= 1'b0;
            rec_op  <= 1'b0;
            clr_req <= 1'b0;

            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= DB_PRESS;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end

                DB_PRESS: begin
                    if (!btn_s) begin
                        // Bounce: abandon the press without a pulse.
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt >= CNT_LAST) begin
                        state    <= FIRE;
                        cnt      <= '0;
                        code_cap <= code_s;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                FIRE: begin
                    state <= WAIT_REL;
                    if (code_cap <= 4'd9) begin
                        rec_num <= 1'b1;
                        digit   <= code_cap;
                    end else if (code_cap != 4'd15) begin
                        rec_op  <= 1'b1;
                        op_code <= 3'(code_cap - 4'd10);
                    end else begin
                        // Clear leaves the held digit/operator untouched.
                        clr_req <= 1'b1;
                    end
                end

                WAIT_REL: begin
                    // Holding the key does nothing: no auto-repeat.
                    if (!btn_s) begin
                        state <= DB_REL;
                        cnt   <= CNT_ONE;
                    end
                end

                DB_REL: begin
                    if (btn_s) begin
                        // Release bounce: go back to waiting, never re-fire.
                        state <= WAIT_REL;
                        cnt   <= '0;
                    end else if (cnt >= CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_key_input.sv
// tb/tb_calc_key_input.sv - scoreboard testbench for calc_key_input
module tb_calc_key_input;

    localparam int DEB = 4;
    // A press driven before edge N shows its pulse in the cycle ending at edge N+DEB+3;
    // the bench cycle counter reads (drive value)+DEB+3 at that cycle's negedge.
    localparam int LAT = DEB + 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_btn;
    logic [3:0] key_code;
    logic       rec_num;
    logic       rec_op;
    logic       clr_req;
    logic [3:0] digit;
    logic [2:0] op_code;
    logic       busy;

    calc_key_input #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(20)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_btn(key_btn),
        .key_code(key_code),
        .rec_num(rec_num),
        .rec_op(rec_op),
        .clr_req(clr_req),
        .digit(digit),
        .op_code(op_code),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int kind;   // 0 digit, 1 operator, 2 clear
        int val;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   model_digit = 0;
    int   model_op    = 0;

    task automatic push_exp(input int code, input int at_cyc);
        exp_t e;
        e.cyc = at_cyc;
        if (code <= 9) begin
            e.kind = 0; e.val = code;
        end else if (code <= 14) begin
            e.kind = 1; e.val = code - 10;
        end else begin
            e.kind = 2; e.val = 0;
        end
        exp_q.push_back(e);
    endtask

    // Output monitor: every pulse must match the head of the queue, in kind, value and cycle.
    exp_t e_mon;
    int   npulse;
    int   kind_got;
    always @(negedge clk) begin
        if (rst_n) begin
            npulse = int'(rec_num) + int'(rec_op) + int'(clr_req);
            if (npulse != 0) begin
                check("one_hot", npulse, 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", npulse, 0);
                end else begin
                    e_mon    = exp_q.pop_front();
                    kind_got = rec_num ? 0 : (rec_op ? 1 : 2);
                    check("pulse_kind", kind_got, e_mon.kind);
                    check("pulse_cycle", cyc, e_mon.cyc);
                    if (e_mon.kind == 0) begin
                        model_digit = e_mon.val;
                        check("digit", int'(digit), model_digit);
                    end else if (e_mon.kind == 1) begin
                        model_op = e_mon.val;
                        check("op_code", int'(op_code), model_op);
                    end else begin
                        check("clr_digit_kept", int'(digit), model_digit);
                        check("clr_op_kept", int'(op_code), model_op);
                    end
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                check("missing_pulse", npulse, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_rec_num"}, int'(rec_num), 0);
        check({tag, "_rec_op"}, int'(rec_op), 0);
        check({tag, "_clr_req"}, int'(clr_req), 0);
        check({tag, "_digit"}, int'(digit), 0);
        check({tag, "_op_code"}, int'(op_code), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic press(input logic [3:0] code, input int hold);
        @(negedge clk);
        key_code = code;
        key_btn  = 1'b1;
        push_exp(int'(code), cyc + LAT);
        repeat (hold) @(negedge clk);
        key_btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    int c0;
    int r0;

    initial begin
        rst_n    = 1'b0;
        key_btn  = 1'b0;
        key_code = 4'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean digit press with release timing of busy.
        @(negedge clk);
        key_code = 4'd7;
        key_btn  = 1'b1;
        push_exp(7, cyc + LAT);
        repeat (30) @(negedge clk);
        key_btn = 1'b0;
        r0 = cyc;
        repeat (5) @(negedge clk);
        check("busy_before_release_done", int'(busy), 1);
        @(negedge clk);
        check("busy_after_release_done", int'(busy), 0);
        check("busy_fall_cycle", cyc - r0, 6);
        repeat (6) @(negedge clk);

        // Bounce rejection, then a sustained press of code 12 (mul).
        @(negedge clk);
        key_code = 4'd12;
        key_btn  = 1'b1;
        @(negedge clk); key_btn = 1'b0;
        @(negedge clk); key_btn = 1'b1;
        @(negedge clk); key_btn = 1'b0;
        @(negedge clk); key_btn = 1'b1;
        push_exp(12, cyc + LAT);
        repeat (10) @(negedge clk);
        key_btn = 1'b0;
        repeat (12) @(negedge clk);

        // Operator sequence.
        press(4'd1, 10);
        press(4'd2, 10);
        press(4'd3, 10);
        press(4'd10, 10);
        press(4'd14, 10);

        // Long hold of clear with a bouncing release.
        @(negedge clk);
        key_code = 4'd15;
        key_btn  = 1'b1;
        push_exp(15, cyc + LAT);
        repeat (200) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            key_btn = 1'b0;
            @(negedge clk);
            key_btn = 1'b1;
            @(negedge clk);
        end
        key_btn = 1'b0;
        repeat (12) @(negedge clk);
        check("clear_keeps_digit", int'(digit), 3);
        check("clear_keeps_op", int'(op_code), 4);

        // Reset while in DB_PRESS.
        @(negedge clk);
        key_code = 4'd5;
        key_btn  = 1'b1;
        c0 = cyc;
        repeat (4) @(negedge clk);
        check("busy_in_db_press", int'(busy), 1);
        rst_n   = 1'b0;
        key_btn = 1'b0;
        #1;
        check_all_zero("rst_db_press");
        model_digit = 0;
        model_op    = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no_pulse_after_rst1_busy", int'(busy), 0);

        // Reset while in FIRE.
        @(negedge clk);
        key_code = 4'd5;
        key_btn  = 1'b1;
        c0 = cyc;
        repeat (6) @(negedge clk);
        check("busy_in_fire", int'(busy), 1);
        rst_n   = 1'b0;
        key_btn = 1'b0;
        #1;
        check_all_zero("rst_fire");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no_pulse_after_rst2_digit", int'(digit), 0);

        // Code change while busy has no effect.
        @(negedge clk);
        key_code = 4'd3;
        key_btn  = 1'b1;
        push_exp(3, cyc + LAT);
        repeat (10) @(negedge clk);
        key_code = 4'd9;
        repeat (10) @(negedge clk);
        key_btn = 1'b0;
        repeat (15) @(negedge clk);
        check("code_change_digit", int'(digit), 3);
        check("final_busy", int'(busy), 0);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/calc_key_input.md
Name: calc_key_input

Overview:
- Front-end stage of the ARM calculator.
- Takes a raw push-button strobe and a 4-bit key-code switch bank, synchronises and debounces them, and classifies each accepted press.
- Emits exactly one single-cycle pulse per press on rec_num (digit) or rec_op (operator/equals), with the decoded value alongside. A clear key emits clr_req.
- Drives the rec_num/rec_op inputs of the calculator state machine directly downstream.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples needed to accept a press or a release. Use 4 in simulation and 500000 in synthesis.
- CNT_W, 20: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_btn  in  1  raw, asynchronous, bouncing "enter key" button.
- key_code  in  4  raw key-code switches; asynchronous, held stable by the user while the button is down.
- rec_num  out  1  one-cycle pulse: accepted key was a digit.
- rec_op  out  1  one-cycle pulse: accepted key was an operator or equals.
- clr_req  out  1  one-cycle pulse: accepted key was clear.
- digit  out  4  value of the last accepted digit (0-9); valid with rec_num, held afterwards.
- op_code  out  3  last accepted operator: 0 add, 1 sub, 2 mul, 3 div, 4 equals; valid with rec_op, held afterwards.
- busy  out  1  high from press detection until release debounce completes.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rec_num=0, rec_op=0, clr_req=0, digit=0, op_code=0, busy=0.
  - Synchroniser flops and code sync flops cleared, counter=0, state=IDLE.
  - All outputs are registered.
- Synchronisation: key_btn and key_code each pass through 2 flops, giving btn_s and code_s (2-cycle delay).
- State machine (IDLE, DB_PRESS, FIRE, WAIT_REL, DB_REL):
  - IDLE: if btn_s=1, go to DB_PRESS with counter=1; else stay.
  - DB_PRESS:
    - btn_s=0 (bounce) -> IDLE, counter=0, no pulse.
    - btn_s=1 and counter=DEBOUNCE_CYCLES-1 -> FIRE, capture code_s.
    - Otherwise counter+1.
  - FIRE (one cycle): assert exactly one pulse from the captured code, then go to WAIT_REL.
  - WAIT_REL: if btn_s=0, go to DB_REL with counter=1. Holding the button indefinitely produces no further pulses (no auto-repeat).
  - DB_REL:
    - btn_s=1 -> WAIT_REL, counter=0.
    - btn_s=0 and counter=DEBOUNCE_CYCLES-1 -> IDLE.
    - Otherwise counter+1.
- Latency: a clean press whose first sampled-high edge is cycle 0 produces its pulse at cycle DEBOUNCE_CYCLES+3 (7 with the default).
- Classification of the captured code:
  - 0-9 -> rec_num=1, digit=code.
  - 10-14 -> rec_op=1, op_code=code-10.
  - 15 -> clr_req=1; digit and op_code unchanged.
  - Exactly one of rec_num/rec_op/clr_req is high in FIRE; all three are low in every other state.
- busy=1 in DB_PRESS, FIRE, WAIT_REL and DB_REL; busy=0 in IDLE.
- key_code changes while busy have no effect after capture.
- The counter saturates at no value: it is only compared against DEBOUNCE_CYCLES-1 and is reset on every state change.
- Reset mid-operation (any state, including FIRE) returns everything to reset values immediately. No pulse is generated after reset deasserts unless a complete new press is debounced.
- Button already held at reset release: treated as a new press and debounced normally, giving one pulse.

Test Plan:
- Clean digit press: key_code=7, key_btn high for 30 cycles then low -> rec_num pulses once, 1 cycle wide, at cycle 7 after the first high sample; digit=7; rec_op=clr_req=0 throughout; busy falls 6 cycles after the release is sampled.
- Bounce rejection: key_btn toggles 1,0,1,0 on successive cycles, then is held high for 10 cycles, with key_code=12 -> no pulse during the bouncing; exactly one rec_op with op_code=2 (mul).
- Operator sequence matching the state-machine bench: digits 1, 2, 3, then codes 10, 14 as five separate clean presses -> three rec_num pulses (digit 1, 2, 3) followed by two rec_op pulses (op_code 0 then 4); never two pulses in the same cycle.
- Long hold and release bounce: key_code=15, button held 200 cycles, release bounces 3 times -> a single clr_req pulse; digit and op_code keep their previous values; no pulse is re-triggered by the release bounce.
- Reset mid-press: assert rst_n=0 in the DB_PRESS state and again in the FIRE state -> all outputs are 0 within the same time step; after release of rst_n with the button low, no pulse occurs.
- Code change while busy: press with key_code=3, change key_code to 9 during WAIT_REL -> digit stays 3; no extra pulse.
